// File: rtl/fifo_collect_pkg.sv
// Shared types and sizing helpers for the systolic result collector.
package fifo_collect_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StSkip,
      StCollect,
      StFull
   } collect_state_e;

   // Counter width that never collapses to zero bits.
   function automatic int unsigned cnt_w(input int unsigned n);
      return ($clog2(n) < 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fifo_collect.sv
// Serial-in, parallel-out collector: drops SKIP skew beats after start, then gathers DEPTH
// signed words into a vector held until the consumer acknowledges with rd.
module fifo_collect
   import fifo_collect_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned BITS  = 32,
   parameter int unsigned SKIP  = DEPTH - 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   en,
   input  logic signed [BITS-1:0] d,
   input  logic                   rd,
   output logic signed [BITS-1:0] q [DEPTH],
   output logic                   valid,
   output logic                   busy
);

   localparam int unsigned IW = cnt_w(DEPTH);
   localparam int unsigned SW = cnt_w(SKIP + 1);
   localparam logic [IW-1:0] IdxLast  = IW'(DEPTH - 1);
   // Only meaningful when SKIP > 0; the skip state is unreachable otherwise.
   localparam logic [SW-1:0] SkipLast = SW'((SKIP == 0) ? 0 : SKIP - 1);

   collect_state_e         state_q, state_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [SW-1:0]          skip_q, skip_d;
   logic signed [BITS-1:0] vec_q [DEPTH];
   logic signed [BITS-1:0] vec_d [DEPTH];

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      skip_d  = skip_q;
      vec_d   = vec_q;
      if (start) begin
         vec_d   = '{default: '0};
         idx_d   = '0;
         skip_d  = '0;
         state_d = (SKIP > 0) ? StSkip : StCollect;
      end else begin
         unique case (state_q)
            StIdle: ;
            StSkip: begin
               if (en) begin
                  skip_d = skip_q + SW'(1);
                  if (skip_q == SkipLast) state_d = StCollect;
               end
            end
            StCollect: begin
               if (en) begin
                  vec_d[idx_q] = d;
                  idx_d        = idx_q + IW'(1);
                  if (idx_q == IdxLast) state_d = StFull;
               end
            end
            StFull: begin
               if (rd) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         idx_q   <= '0;
         skip_q  <= '0;
         vec_q   <= '{default: '0};
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         skip_q  <= skip_d;
         vec_q   <= vec_d;
      end
   end

   assign q     = vec_q;
   assign valid = (state_q == StFull);
   assign busy  = (state_q == StSkip) || (state_q == StCollect);

endmodule
